lfsr8_rewind: RTL
=================

Name: lfsr8_rewind

Overview:
- Inverse of the 8-bit challenge LFSR used on the serial PUF path.
- The forward LFSR shifts left, inserting new = s[1]^s[2]^s[3]^s[7] at bit 0.
- This block takes an observed challenge state plus a step count, steps the LFSR backward that many times, and returns the originating seed.
- Used by the host-side / response-checking logic to recover which seed produced a logged challenge.

Parameters:
- CNT_W, 16, width of the step-count input and internal down-counter.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_state  input  8  observed (final) LFSR state.
- in_steps  input  CNT_W  number of forward steps to undo.
- abort  input  1  synchronous cancel of the current job.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_seed  output  8  recovered seed.
- out_match  output  1  verification flag; see Optional Feature.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_seed=0x00, out_match=0, counter=0.
- Backward step: prev = {s[0]^s[2]^s[3]^s[4], s[7:1]}. 0x00 is a fixed point in both directions.
- FSM states: IDLE, REWIND, VERIFY (macro only), DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_state into the work register and the target register, and in_steps into the counter.
  - Next state is REWIND if in_steps≠0, else DONE.
- REWIND:
  - Each cycle: work ← backstep(work), counter ← counter−1.
  - When counter==1 at the edge, go to DONE (or VERIFY under the macro).
- Latency: out_valid rises exactly N clock edges after the accepting edge (N=in_steps). For N=0, out_valid is high in the cycle immediately after acceptance.
- DONE:
  - out_valid=1, out_seed=work. Both held stable until out_ready.
  - On out_valid&&out_ready: go to IDLE.
  - in_ready stays low that cycle (no bypass); the next request can be accepted one cycle later.
- in_ready=0 in every state except IDLE. in_valid is ignored while busy.
- abort:
  - In REWIND, VERIFY or DONE: return to IDLE next edge, drop out_valid, leave out_seed unchanged.
  - In IDLE: no effect.
  - abort wins over a simultaneous out_ready.
- Async reset mid-operation: the job is discarded and all outputs return to their reset values.
- Counter is full CNT_W width; the maximum in_steps (2^CNT_W−1) must complete correctly with no wrap.

Optional Feature:
- Macro: LFSR8_REWIND_VERIFY_EN.
- Defined:
  - After REWIND, enter VERIFY. The counter is reloaded with N and the seed is stepped forward N times into a scratch register.
  - out_match = (scratch == captured in_state). Total latency is 2N edges after acceptance (N=0: immediately following cycle, out_match=1).
  - out_match is valid with out_valid.
- Not defined:
  - No VERIFY state and no scratch register.
  - out_match is tied to 1 whenever out_valid=1, and 0 otherwise.

Decomposition:
- Package lfsr8_pkg:
  - LFSR width constant (8) and tap constants (1,2,3,7).
  - FSM state enum typedef.
  - Functions lfsr8_fwd_step and lfsr8_back_step.
- No sub-module: the step logic is single-line functions, and the FSM plus counter stay in lfsr8_rewind.

Test Plan:
1. Reset values: hold reset_n=0 with in_valid pulsed → in_ready=1, out_valid=0, out_seed=0x00, out_match=0. Release, idle 3 cycles → unchanged.
2. Basic rewind: in_state=0x16, in_steps=4 (forward chain 0x01→0x02→0x05→0x0B→0x16) → out_seed=0x01, out_valid exactly 4 edges after accept (8 with macro), out_match=1.
3. Zero-step passthrough: in_state=0xA5, in_steps=0 → out_valid in the next cycle, out_seed=0xA5. Fixed point: in_state=0x00, in_steps=5 → out_seed=0x00.
4. Backpressure: in_state=0x0B, in_steps=2 with out_ready=0 for 5 cycles → out_seed=0x02 held stable, in_ready=0 throughout. Then out_ready=1 → next cycle out_valid=0, and in_ready=1 one cycle later.
5. Abort and reset mid-job:
   - Start in_steps=1000 and assert abort at cycle 10 → IDLE next edge, out_valid never rises.
   - Repeat with reset_n pulsed low mid-REWIND → all outputs at reset values immediately.
   - A following request (0x16, 4) → 0x01.
6. Random round-trip: 200 random seeds and step counts 0..300, run a forward model then rewind → out_seed equals seed every time, out_match=1 with the macro.

Source files
------------

// File: rtl/lfsr8_pkg.sv
// Shared constants, FSM state type and single-step helpers for the 8-bit
// challenge LFSR and its inverse.
package lfsr8_pkg;

  localparam int unsigned LFSR_W = 8;
  localparam int unsigned TAP_A  = 1;
  localparam int unsigned TAP_B  = 2;
  localparam int unsigned TAP_C  = 3;
  localparam int unsigned TAP_D  = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REWIND = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } lfsr8_state_e;

  // One forward step: shift left, feedback from taps 1,2,3,7 into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr8_fwd_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
  endfunction

  // One backward step: recover the bit that was shifted out of bit 7.
  function automatic logic [LFSR_W-1:0] lfsr8_back_step(input logic [LFSR_W-1:0] s);
    return {s[0] ^ s[TAP_A+1] ^ s[TAP_B+1] ^ s[TAP_C+1], s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/lfsr8_rewind.sv
// Rewinds an observed 8-bit challenge LFSR state by a given number of steps
// to recover its originating seed.
// Optional macro LFSR8_REWIND_VERIFY_EN adds a forward re-check of the
// recovered seed and reports the outcome on out_match.
module lfsr8_rewind
  import lfsr8_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_state,
  input  logic [CNT_W-1:0]  in_steps,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_seed,
  output logic              out_match
);

  lfsr8_state_e        r_state,     w_state_nxt;
  logic [LFSR_W-1:0]   r_work,      w_work_nxt;
  logic [CNT_W-1:0]    r_cnt,       w_cnt_nxt;
  logic                r_in_ready,  w_in_ready_nxt;
  logic                r_out_valid, w_out_valid_nxt;
  logic [LFSR_W-1:0]   r_out_seed,  w_out_seed_nxt;
  logic                r_out_match, w_out_match_nxt;
  logic                w_last;

`ifdef LFSR8_REWIND_VERIFY_EN
  logic [LFSR_W-1:0]   r_target,    w_target_nxt;
  logic [CNT_W-1:0]    r_steps,     w_steps_nxt;
  logic [LFSR_W-1:0]   r_scratch,   w_scratch_nxt;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_seed  = r_out_seed;
  assign out_match = r_out_match;

  assign w_last = (r_cnt == CNT_W'(1));

  // Next-state, datapath and registered-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_work_nxt      = r_work;
    w_cnt_nxt       = r_cnt;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    w_out_seed_nxt  = r_out_seed;
    w_out_match_nxt = r_out_match;
`ifdef LFSR8_REWIND_VERIFY_EN
    w_target_nxt    = r_target;
    w_steps_nxt     = r_steps;
    w_scratch_nxt   = r_scratch;
`endif

    case (r_state)
      ST_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_work_nxt     = in_state;
          w_cnt_nxt      = in_steps;
          w_in_ready_nxt = 1'b0;
`ifdef LFSR8_REWIND_VERIFY_EN
          w_target_nxt   = in_state;
          w_steps_nxt    = in_steps;
`endif
          if (in_steps != '0) begin
            w_state_nxt = ST_REWIND;
          end else begin
            // Zero steps: the observed state is already the seed.
            w_state_nxt     = ST_DONE;
            w_out_valid_nxt = 1'b1;
            w_out_seed_nxt  = in_state;
            w_out_match_nxt = 1'b1;
          end
        end
      end

      ST_REWIND: begin
        if (abort) begin
          w_state_nxt    = ST_IDLE;
          w_in_ready_nxt = 1'b1;
        end else begin
          w_work_nxt = lfsr8_back_step(r_work);
          w_cnt_nxt  = r_cnt - CNT_W'(1);
          if (w_last) begin
`ifdef LFSR8_REWIND_VERIFY_EN
            w_state_nxt   = ST_VERIFY;
            w_cnt_nxt     = r_steps;
            w_scratch_nxt = lfsr8_back_step(r_work);
`else
            w_state_nxt     = ST_DONE;
            w_out_valid_nxt = 1'b1;
            w_out_seed_nxt  = lfsr8_back_step(r_work);
            w_out_match_nxt = 1'b1;
`endif
          end
        end
      end

`ifdef LFSR8_REWIND_VERIFY_EN
      ST_VERIFY: begin
        if (abort) begin
          w_state_nxt    = ST_IDLE;
          w_in_ready_nxt = 1'b1;
        end else begin
          w_scratch_nxt = lfsr8_fwd_step(r_scratch);
          w_cnt_nxt     = r_cnt - CNT_W'(1);
          if (w_last) begin
            w_state_nxt     = ST_DONE;
            w_out_valid_nxt = 1'b1;
            w_out_seed_nxt  = r_work;
            w_out_match_nxt = (lfsr8_fwd_step(r_scratch) == r_target);
          end
        end
      end
`endif

      ST_DONE: begin
        // abort and out_ready lead to the same place; seed is left as is.
        if (abort || out_ready) begin
          w_state_nxt     = ST_IDLE;
          w_out_valid_nxt = 1'b0;
          w_out_match_nxt = 1'b0;
          w_in_ready_nxt  = 1'b1;
        end
      end

      default: begin
        w_state_nxt     = ST_IDLE;
        w_in_ready_nxt  = 1'b1;
        w_out_valid_nxt = 1'b0;
        w_out_match_nxt = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_work      <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_seed  <= '0;
      r_out_match <= 1'b0;
`ifdef LFSR8_REWIND_VERIFY_EN
      r_target    <= '0;
      r_steps     <= '0;
      r_scratch   <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_work      <= w_work_nxt;
      r_cnt       <= w_cnt_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_seed  <= w_out_seed_nxt;
      r_out_match <= w_out_match_nxt;
`ifdef LFSR8_REWIND_VERIFY_EN
      r_target    <= w_target_nxt;
      r_steps     <= w_steps_nxt;
      r_scratch   <= w_scratch_nxt;
`endif
    end
  end

endmodule
